// File: rtl/instr_fetch.sv
// Instruction fetch stage: issues word reads for incoming PCs, tracks in-flight requests,
// and buffers returned words in order for decode. Handles redirect flushes and misaligned PCs.
module instr_fetch #(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        pc_valid_i,
    output logic        pc_ready_o,
    input  logic        flush_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_fault_o,
    input  logic        instr_ready_i,
    output logic        proto_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW+1:0] DEPTH_C = (CW+2)'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } fetch_ent_t;

    logic [CW-1:0] outstanding, discard, fcount;
    logic [AW-1:0] pq_rd, pq_wr, f_rd, f_wr;
    logic [31:0]   pq_mem [DEPTH];
    fetch_ent_t    f_mem  [DEPTH];
    logic [31:0]   last_instr, last_pc;
    logic          proto_err_q;

    logic [CW+1:0] used;
    logic          space, aligned, req, hs, mis_acc;
    logic          rsp_drop, rsp_take, rsp_err, push, pop;
    fetch_ent_t    push_ent, head;

    // Every credit (in flight, being discarded, or buffered) reserves one FIFO slot.
    assign used    = {2'b00, outstanding} + {2'b00, discard} + {2'b00, fcount};
    assign space   = (used < DEPTH_C);
    assign aligned = (pc_i[1:0] == 2'b00);

    assign req     = ~rst & pc_valid_i & aligned & space & ~flush_i;
    assign hs      = req & imem_gnt_i;
    // Misaligned PCs wait until the memory side is idle so the fault lands in program order.
    assign mis_acc = ~rst & pc_valid_i & ~aligned & (outstanding == '0) & (discard == '0)
                   & space & ~flush_i;

    assign imem_req_o  = req;
    assign imem_addr_o = {pc_i[31:2], 2'b00};
    assign pc_ready_o  = hs | mis_acc;

    assign rsp_drop = imem_rvalid_i & (discard != '0);
    assign rsp_take = imem_rvalid_i & (discard == '0) & (outstanding != '0);
    assign rsp_err  = imem_rvalid_i & (discard == '0) & (outstanding == '0);

    assign head          = f_mem[f_rd];
    assign instr_valid_o = (fcount != '0);
    assign instr_o       = instr_valid_o ? head.instr : last_instr;
    assign instr_pc_o    = instr_valid_o ? head.pc    : last_pc;
    assign instr_fault_o = instr_valid_o & head.fault;
    assign proto_err_o   = proto_err_q;

    assign push = ~flush_i & (rsp_take | mis_acc);
    assign pop  = ~flush_i & instr_valid_o & instr_ready_i;

    always_comb begin
        push_ent = '{pc: pc_i, instr: NOP_INSTR, fault: 1'b1};
        if (rsp_take)
            push_ent = '{pc: pq_mem[pq_rd], instr: imem_rdata_i, fault: 1'b0};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            outstanding <= '0;
            discard     <= '0;
            fcount      <= '0;
            pq_rd       <= '0;
            pq_wr       <= '0;
            f_rd        <= '0;
            f_wr        <= '0;
            proto_err_q <= 1'b0;
            last_instr  <= NOP_INSTR;
            last_pc     <= '0;
        end else begin
            if (rsp_err)
                proto_err_q <= 1'b1;
            if (instr_valid_o) begin
                last_instr <= instr_o;
                last_pc    <= instr_pc_o;
            end
            if (flush_i) begin
                // Everything still owed by memory becomes stale, except a live word returning now.
                discard     <= discard + outstanding - CW'(rsp_drop | rsp_take);
                outstanding <= '0;
                fcount      <= '0;
                pq_rd       <= '0;
                pq_wr       <= '0;
                f_rd        <= '0;
                f_wr        <= '0;
            end else begin
                discard     <= discard - CW'(rsp_drop);
                outstanding <= outstanding + CW'(hs) - CW'(rsp_take);
                fcount      <= fcount + CW'(push) - CW'(pop);
                if (hs)
                    pq_wr <= pq_wr + AW'(1);
                if (rsp_take)
                    pq_rd <= pq_rd + AW'(1);
                if (push)
                    f_wr <= f_wr + AW'(1);
                if (pop)
                    f_rd <= f_rd + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs)
            pq_mem[pq_wr] <= pc_i;
        if (push)
            f_mem[f_wr] <= push_ent;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic against a queue-based model
// of the memory and the decode stream; a separate monitor scores every presented instruction.
module tb_instr_fetch;
    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        pc_valid_i, pc_ready_o, flush_i;
    logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
    logic [31:0] imem_addr_o, imem_rdata_i;
    logic        instr_valid_o, instr_fault_o, instr_ready_i, proto_err_o;
    logic [31:0] instr_o, instr_pc_o;

    always #5 clk = ~clk;

    instr_fetch #(.DEPTH(DEPTH), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .pc_valid_i(pc_valid_i), .pc_ready_o(pc_ready_o),
        .flush_i(flush_i), .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_o(instr_o), .instr_pc_o(instr_pc_o),
        .instr_fault_o(instr_fault_o), .instr_ready_i(instr_ready_i), .proto_err_o(proto_err_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } exp_t;
    typedef struct {
        logic [31:0] addr;
        bit          stale;
    } mreq_t;

    exp_t  exp_q[$];   // words decode should see, in order
    mreq_t mem_q[$];   // reads granted by memory, not yet returned
    int    fcnt = 0;   // words sitting in the fetch buffer
    bit    perr = 1'b0;
    bit    mon_en = 1'b0;
    int    checks = 0, errors = 0;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hAAAA0001;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: scores the buffer head whenever it is presented, pops on consumption.
    always @(negedge clk) begin
        if (mon_en && !rst && instr_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL head_unexpected: got pc %h expected no entry at %0t", instr_pc_o, $time);
            end else begin
                chk("head_pc", instr_pc_o, exp_q[0].pc);
                chk("head_instr", instr_o, exp_q[0].instr);
                chk("head_fault", {31'd0, instr_fault_o}, {31'd0, exp_q[0].fault});
                if (instr_ready_i && !flush_i)
                    void'(exp_q.pop_front());
            end
        end
    end

    // One cycle: called just after a rising edge, returns just after the next one.
    task automatic cycle(input logic pv, input logic [31:0] pc, input logic gnt, input bit rv_en,
                         input bit proto, input logic rdy, input logic fl, output bit acc);
        int    used;
        bit    space, e_req, e_hs, e_mis, rv, pop;
        mreq_t m;
        pc_valid_i = pv; pc_i = pc; imem_gnt_i = gnt; instr_ready_i = rdy; flush_i = fl;
        if (mem_q.size() > 0) begin
            rv = rv_en;
            imem_rdata_i = mdata(mem_q[0].addr);
        end else begin
            rv = proto;
            imem_rdata_i = $urandom;
        end
        imem_rvalid_i = rv;
        @(negedge clk);
        used  = mem_q.size() + fcnt;
        space = used < DEPTH;
        e_req = pv && (pc[1:0] == 2'b00) && space && !fl;
        e_hs  = e_req && gnt;
        e_mis = pv && (pc[1:0] != 2'b00) && (mem_q.size() == 0) && space && !fl;
        acc   = e_hs || e_mis;
        chk("imem_req", {31'd0, imem_req_o}, {31'd0, e_req});
        chk("pc_ready", {31'd0, pc_ready_o}, {31'd0, acc});
        if (e_req)
            chk("imem_addr", imem_addr_o, {pc[31:2], 2'b00});
        chk("instr_valid", {31'd0, instr_valid_o}, {31'd0, fcnt > 0});
        chk("proto_err", {31'd0, proto_err_o}, {31'd0, perr});
        @(posedge clk);
        pop = (fcnt > 0) && rdy && !fl;
        if (rv && mem_q.size() > 0) begin
            m = mem_q.pop_front();
            if (!m.stale && !fl) begin
                exp_q.push_back('{pc: m.addr, instr: mdata(m.addr), fault: 1'b0});
                fcnt++;
            end
        end else if (rv) begin
            perr = 1'b1;
        end
        if (e_mis) begin
            exp_q.push_back('{pc: pc, instr: NOP, fault: 1'b1});
            fcnt++;
        end
        if (fl) begin
            exp_q.delete();
            fcnt = 0;
            foreach (mem_q[i]) mem_q[i].stale = 1'b1;
        end else if (pop) begin
            fcnt--;
        end
        if (e_hs)
            mem_q.push_back('{addr: pc, stale: 1'b0});
        #1;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
    endtask

    initial begin
        bit          a;
        logic [31:0] rpc;
        rst = 1'b1; pc_valid_i = 1'b1; pc_i = 32'h0; flush_i = 1'b0; imem_gnt_i = 1'b1;
        imem_rvalid_i = 1'b0; imem_rdata_i = 32'h0; instr_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst_instr", instr_o, NOP);
        chk("rst_pc", instr_pc_o, 32'd0);
        chk("rst_pc_ready", {31'd0, pc_ready_o}, 32'd0);
        chk("rst_req", {31'd0, imem_req_o}, 32'd0);
        chk("rst_proto", {31'd0, proto_err_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // back-to-back fetches with immediate responses
        cycle(1'b1, 32'h0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, a);
        cycle(1'b1, 32'h4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, a);
        idle(4);

        // backpressure: buffer fills, one pop frees exactly one credit
        cycle(1'b1, 32'h8, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 32'hC, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b1, 32'h10, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, a);
        for (int i = 0; i < 4; i++) cycle(1'b1, 32'h14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a);
        idle(6);

        // flush with two reads in flight, then a redirected fetch
        cycle(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a);
        cycle(1'b1, 32'h24, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, a);
        cycle(1'b1, 32'h28, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, a);
        a = 1'b0;
        for (int i = 0; i < 12 && !a; i++) cycle(1'b1, 32'h100, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, a);
        checks++;
        if (!a) begin
            errors++;
            $display("FAIL flush_redirect: got no accept expected accept of pc 00000100");
        end
        idle(4);

        // misaligned PC with nothing outstanding
        cycle(1'b1, 32'h102, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, a);
        cycle(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, a);
        idle(3);

        // random traffic
        rpc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] p;
            p = ($urandom_range(15) == 0) ? (rpc | 32'($urandom_range(1, 3))) : rpc;
            cycle($urandom_range(3) != 0, p, $urandom_range(3) != 0, $urandom_range(1) == 1,
                  $urandom_range(63) == 0, $urandom_range(2) != 0, $urandom_range(31) == 0, a);
            if (a) rpc = ($urandom_range(7) == 0) ? {$urandom_range(32'hFFFF), 2'b00} : rpc + 32'd4;
        end
        idle(10);
        chk("drain_empty", 32'(exp_q.size()), 32'd0);

        // reset mid-run, then a response with nothing outstanding
        cycle(1'b1, 32'h200, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a);
        rst = 1'b1;
        @(negedge clk);
        chk("rst2_valid", {31'd0, instr_valid_o}, 32'd0);
        chk("rst2_instr", instr_o, NOP);
        chk("rst2_proto", {31'd0, proto_err_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete(); mem_q.delete(); fcnt = 0; perr = 1'b0;
        cycle(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, a);
        idle(2);
        chk("proto_sticky", {31'd0, proto_err_o}, 32'd1);
        chk("proto_fifo", {31'd0, instr_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
